// File: rtl/tdc_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_measure_ctrl
// Sequencer for one TDC measurement channel built around fine_counter.
// It arms the channel and detects the start and stop hits. It counts whole clk
// cycles (the coarse count) between the two hits. It then waits for the fine
// encoder to settle and merges the coarse and fine codes into one result word.
// The result is offered on a valid/ready handshake. After the handshake the
// fine delay line is held in reset for CLR_CYC cycles.
//
// Optional feature macro: TDC_TIMEOUT_EN
//   When defined, a run that reaches a coarse count of TIMEOUT without a stop
//   hit is aborted. It returns {TIMEOUT, 0} with timeout=1.
//   When undefined, RUN waits for stop indefinitely and timeout stays 0.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   arm          in   1-cycle pulse, arms one measurement (ignored while busy)
//   start_hit    in   asynchronous start event, rising edge significant
//   stop_hit     in   asynchronous stop event, rising edge significant
//   fine_data    in   encoded fine code from fine_counter
//   fine_start   out  drives fine_counter.start
//   fine_reset   out  drives fine_counter.reset (active-high)
//   result       out  {coarse, fine}
//   result_valid out  result holds a completed measurement
//   result_ready in   consumer accepts result
//   busy         out  high in every state except IDLE
//   overflow     out  coarse counter saturated during this result
//   timeout      out  result is an aborted measurement
// -----------------------------------------------------------------------------
module tdc_measure_ctrl #(
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 10,
  parameter int FINE_LAT = 3,
  parameter int CLR_CYC  = 2,
  parameter int TIMEOUT  = 4000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       start_hit,
  input  logic                       stop_hit,
  input  logic [FINE_W-1:0]          fine_data,
  output logic                       fine_start,
  output logic                       fine_reset,
  output logic [COARSE_W+FINE_W-1:0] result,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       busy,
  output logic                       overflow,
  output logic                       timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    CLEAR  = 3'd5
  } state_t;

  localparam logic [COARSE_W-1:0] COARSE_MAX = {COARSE_W{1'b1}};
  localparam logic [COARSE_W-1:0] TIMEOUT_C  = COARSE_W'(TIMEOUT);
  localparam logic [3:0]          FINE_LAT_C = 4'(FINE_LAT);
  localparam logic [3:0]          CLR_LAST_C = 4'(CLR_CYC - 1);

  state_t                       state_r, state_nxt_s;
  logic [2:0]                   start_sync_r, stop_sync_r;
  logic                         start_edge_s, stop_edge_s;
  logic [3:0]                   cnt_r, cnt_nxt_s;
  logic [COARSE_W-1:0]          coarse_r, coarse_nxt_s, coarse_inc_s;
  logic [COARSE_W+FINE_W-1:0]   result_r, result_nxt_s;
  logic                         valid_r, valid_nxt_s;
  logic                         overflow_r, overflow_nxt_s;
  logic                         timeout_r, timeout_nxt_s;
  logic                         fine_start_r, fine_start_nxt_s;
  logic                         fine_reset_r, fine_reset_nxt_s;
  logic                         busy_r;

`ifndef TDC_TIMEOUT_EN
  // Without the abort feature the limit constant has no consumer.
  logic [COARSE_W-1:0] timeout_unused_s;
  assign timeout_unused_s = TIMEOUT_C;
`endif

  // Bit 1 is the synchronised level and bit 2 is its one-cycle-old copy.
  assign start_edge_s = start_sync_r[1] & ~start_sync_r[2];
  assign stop_edge_s  = stop_sync_r[1]  & ~stop_sync_r[2];

  // The coarse count saturates instead of wrapping.
  assign coarse_inc_s = (coarse_r == COARSE_MAX) ? coarse_r : coarse_r + COARSE_W'(1);

  // Hit synchronisers and edge-history flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_sync_r <= 3'b000;
      stop_sync_r  <= 3'b000;
    end else begin
      start_sync_r <= {start_sync_r[1:0], start_hit};
      stop_sync_r  <= {stop_sync_r[1:0],  stop_hit};
    end
  end

  // State register plus every registered output and datapath register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      coarse_r     <= '0;
      result_r     <= '0;
      valid_r      <= 1'b0;
      overflow_r   <= 1'b0;
      timeout_r    <= 1'b0;
      fine_start_r <= 1'b0;
      fine_reset_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      coarse_r     <= coarse_nxt_s;
      result_r     <= result_nxt_s;
      valid_r      <= valid_nxt_s;
      overflow_r   <= overflow_nxt_s;
      timeout_r    <= timeout_nxt_s;
      fine_start_r <= fine_start_nxt_s;
      fine_reset_r <= fine_reset_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
    end
  end

  // Next-state and next-register-value logic.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    coarse_nxt_s     = coarse_r;
    result_nxt_s     = result_r;
    valid_nxt_s      = valid_r;
    overflow_nxt_s   = overflow_r;
    timeout_nxt_s    = timeout_r;
    fine_start_nxt_s = fine_start_r;
    fine_reset_nxt_s = fine_reset_r;
    case (state_r)
      IDLE: begin
        fine_start_nxt_s = 1'b0;
        if (arm) begin
          state_nxt_s      = ARMED;
          fine_reset_nxt_s = 1'b0;
          overflow_nxt_s   = 1'b0;
          timeout_nxt_s    = 1'b0;
        end else begin
          fine_reset_nxt_s = 1'b1;
        end
      end
      ARMED: begin
        // A lone stop edge is ignored. A start edge together with a stop
        // edge yields a zero-length run.
        if (start_edge_s) begin
          coarse_nxt_s     = '0;
          fine_start_nxt_s = 1'b1;
          cnt_nxt_s        = 4'd0;
          if (stop_edge_s) begin
            state_nxt_s = SETTLE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = ARMED;
        end
      end
      RUN: begin
        // The stop-edge cycle still counts, so coarse equals the number of
        // clk edges between the detected start and stop edges.
        if (stop_edge_s) begin
          coarse_nxt_s   = coarse_inc_s;
          overflow_nxt_s = overflow_r | (coarse_inc_s == COARSE_MAX);
          cnt_nxt_s      = 4'd0;
          state_nxt_s    = SETTLE;
`ifdef TDC_TIMEOUT_EN
        end else if (coarse_r == TIMEOUT_C) begin
          result_nxt_s  = {TIMEOUT_C, {FINE_W{1'b0}}};
          timeout_nxt_s = 1'b1;
          valid_nxt_s   = 1'b1;
          state_nxt_s   = DONE;
`endif
        end else begin
          coarse_nxt_s   = coarse_inc_s;
          overflow_nxt_s = overflow_r | (coarse_inc_s == COARSE_MAX);
        end
      end
      SETTLE: begin
        // FINE_LAT full cycles pass before fine_data is sampled.
        if (cnt_r == FINE_LAT_C) begin
          result_nxt_s = {coarse_r, fine_data};
          valid_nxt_s  = 1'b1;
          state_nxt_s  = DONE;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      DONE: begin
        if (valid_r && result_ready) begin
          valid_nxt_s      = 1'b0;
          fine_start_nxt_s = 1'b0;
          fine_reset_nxt_s = 1'b1;
          cnt_nxt_s        = 4'd0;
          state_nxt_s      = CLEAR;
        end else begin
          state_nxt_s = DONE;
        end
      end
      CLEAR: begin
        if (cnt_r == CLR_LAST_C) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign fine_start   = fine_start_r;
  assign fine_reset   = fine_reset_r;
  assign result       = result_r;
  assign result_valid = valid_r;
  assign busy         = busy_r;
  assign overflow     = overflow_r;
  assign timeout      = timeout_r;

endmodule
